// File: rtl/maxpool_stream_32_2_16.sv
// Streaming 1-D signed max-pool over non-overlapping K-word windows within LEN-word frames,
// with a small output FIFO so that back-pressure on the output stalls the input.
module maxpool_stream_32_2_16 #(
    parameter int WIDTH  = 16,
    parameter int LEN    = 32,
    parameter int K      = 2,
    parameter int LOGLEN = 6,
    parameter int D      = 4,
    parameter int LOGD   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_x,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic [WIDTH-1:0] m_data_out_y,
    output logic             m_valid_y,
    input  logic             m_ready_y
);
    localparam logic [LOGLEN-1:0] POS_LAST  = LOGLEN'(LEN - 1);
    localparam logic [LOGLEN-1:0] WCNT_LAST = LOGLEN'(K - 1);
    localparam logic [LOGD:0]     DEPTH     = (LOGD + 1)'(D);
    localparam logic [LOGD-1:0]   PTR_LAST  = LOGD'(D - 1);

    logic signed [WIDTH-1:0] mem [D];
    logic [LOGD-1:0]         rd_ptr, wr_ptr;
    logic [LOGD:0]           count;
    logic signed [WIDTH-1:0] acc, din, cand;
    logic [LOGLEN-1:0]       wcnt, pos;
    logic                    accept, pop, close, push;

    assign din          = s_data_in_x;
    assign s_ready_x    = !reset && (count < DEPTH);
    assign m_valid_y    = (count != '0);
    assign m_data_out_y = mem[rd_ptr];

    assign accept = s_valid_x && s_ready_x;
    assign pop    = m_valid_y && m_ready_y;
    assign close  = (wcnt == WCNT_LAST) || (pos == POS_LAST);
    assign push   = accept && close;

    // First word of a window seeds it; later words fold in by signed max.
    always_comb begin
        cand = acc;
        if (wcnt == '0 || din > acc) cand = din;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cand;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            acc    <= '0;
            wcnt   <= '0;
            pos    <= '0;
        end else begin
            if (accept) begin
                pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                if (close) begin
                    wcnt <= '0;
                end else begin
                    acc  <= cand;
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_maxpool_stream_32_2_16.sv
// Scoreboard bench for the max-pool stage: a LEN=32 instance and a LEN=5 instance for partial windows.
module tb_maxpool_stream_32_2_16;
    logic        clk = 0, reset = 1;
    logic [15:0] sd = '0, d5 = '0;
    logic        sv = 0, v5 = 0;
    logic        sr, r5;
    logic [15:0] md, m5d;
    logic        mv, m5v;
    logic        mr = 1, mr5 = 1;

    int total = 0, bad = 0;
    logic [15:0] q [$];
    logic [15:0] q5 [$];
    bit rnd_done;

    always #5 clk = ~clk;

    maxpool_stream_32_2_16 dut (
        .clk(clk), .reset(reset), .s_data_in_x(sd), .s_valid_x(sv), .s_ready_x(sr),
        .m_data_out_y(md), .m_valid_y(mv), .m_ready_y(mr));

    maxpool_stream_32_2_16 #(.LEN(5), .K(2), .LOGLEN(3)) dut5 (
        .clk(clk), .reset(reset), .s_data_in_x(d5), .s_valid_x(v5), .s_ready_x(r5),
        .m_data_out_y(m5d), .m_valid_y(m5v), .m_ready_y(mr5));

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Monitors: sample just after the negedge, when inputs for the next edge are settled.
    always begin
        @(negedge clk); #1;
        if (mv && mr) begin
            if (q.size() == 0) check("out_unexpected", $signed(md), 99999);
            else check("out", $signed(md), $signed(q.pop_front()));
        end
    end

    always begin
        @(negedge clk); #1;
        if (m5v && mr5) begin
            if (q5.size() == 0) check("out5_unexpected", $signed(m5d), 99999);
            else check("out5", $signed(m5d), $signed(q5.pop_front()));
        end
    end

    // Present a word at a negedge; it is accepted on the first posedge where ready is high.
    task automatic send(input bit sel, input int v);
        int n = 0;
        @(negedge clk);
        if (sel) begin v5 = 1; d5 = 16'(v); end
        else     begin sv = 1; sd = 16'(v); end
        while (!(sel ? r5 : sr) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("send_timeout", n, 0);
    endtask

    task automatic idle();
        @(negedge clk); sv = 0; v5 = 0;
    endtask

    task automatic exp(input int v);
        q.push_back(16'(v));
    endtask

    initial begin
        int bp_in[16]  = '{10, -2, 3, 30, -7, -9, 100, 99, 5, 6, -1, -1, 40, 41, 0, -50};
        int bp_out[8]  = '{10, 30, -7, 100, 6, -1, 41, 0};
        int sg_in[8]   = '{-5, -3, 7, -8, -32768, -1, 0, 0};
        int p5_in[9]   = '{3, 9, 4, 1, 6, 2, 8, 5, 5};
        int p5_out[5]  = '{9, 4, 6, 8, 5};
        logic signed [15:0] rdat [96];
        logic signed [15:0] m;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready", sr, 0);
        check("rst_m_valid", mv, 0);
        reset = 0;
        @(negedge clk);
        check("post_rst_s_ready", sr, 1);
        check("post_rst_m_valid", mv, 0);

        // Partial window at frame end (LEN=5): second frame starts fresh
        foreach (p5_out[i]) q5.push_back(16'(p5_out[i]));
        foreach (p5_in[i]) send(1, p5_in[i]);
        idle();

        // Ramp 1..32 with first-result latency
        for (int i = 1; i <= 16; i++) exp(2 * i);
        send(0, 1);
        send(0, 2);
        check("lat_before", mv, 0);
        @(negedge clk); sv = 0;
        check("lat_after", mv, 1);
        for (int i = 3; i <= 32; i++) send(0, i);
        idle();

        // Signed windows
        exp(-3); exp(7); exp(-1); exp(0);
        foreach (sg_in[i]) send(0, sg_in[i]);
        idle();
        repeat (4) @(negedge clk);

        // Back-pressure: 4 results fill the FIFO, input stalls
        mr = 0;
        foreach (bp_out[i]) exp(bp_out[i]);
        for (int i = 0; i < 8; i++) send(0, bp_in[i]);
        @(negedge clk); sv = 0;
        check("bp_s_ready_low", sr, 0);
        check("bp_m_valid", mv, 1);
        repeat (3) @(negedge clk);
        check("bp_s_ready_hold", sr, 0);
        mr = 1;
        for (int i = 8; i < 16; i++) send(0, bp_in[i]);
        idle();
        repeat (8) @(negedge clk);
        check("bp_q_drained", q.size(), 0);

        // Reset mid-operation discards queued results and the open window
        mr = 0;
        for (int i = 1; i <= 5; i++) send(0, i);
        idle();
        check("pre_rst_m_valid", mv, 1);
        reset = 1;
        @(negedge clk);
        check("mid_rst_m_valid", mv, 0);
        check("mid_rst_s_ready", sr, 0);
        reset = 0;
        @(negedge clk);
        check("after_rst_m_valid", mv, 0);
        mr = 1;
        exp(7);
        send(0, 1); send(0, 7);
        idle();
        repeat (4) @(negedge clk);

        // Random stalls over 3 frames of random signed data
        reset = 1; @(negedge clk); reset = 0;
        for (int i = 0; i < 96; i++) rdat[i] = 16'($urandom);
        for (int i = 0; i < 96; i += 2) begin
            m = (rdat[i+1] > rdat[i]) ? rdat[i+1] : rdat[i];
            exp(m);
        end
        rnd_done = 0;
        fork
            while (!rnd_done) begin @(negedge clk); mr = 1'($urandom_range(0, 1)); end
            begin
                for (int i = 0; i < 96; i++) begin
                    repeat ($urandom_range(0, 2)) idle();
                    send(0, rdat[i]);
                end
                idle();
                rnd_done = 1;
            end
        join
        @(negedge clk); mr = 1;
        repeat (20) @(negedge clk);
        check("final_q_empty", q.size(), 0);
        check("final_q5_empty", q5.size(), 0);
        check("final_m_valid", mv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d", total);
        $fatal(1);
    end
endmodule
